cgra_route_reader: RTL
======================

// Module: cgra_route_reader
// PURPOSE
//  Reads back a routed path from the CGRA routing table (one 6-bit cell per PE) for one edge (src,dst).
//  Walks the direction bits hop by hop from src toward dst and streams each hop out over valid/ready.
//  Ends each request with a status: OK, BROKEN, TOO_LONG or BYPASS.
//  Consumer side of the router's table writes; feeds config serialisation and route checking.
// PARAMETERS
//  GRID        4   PEs per grid line; node = row*GRID + col
//  NODES       16  GRID*GRID; table depth
//  NODE_W      4   node index width, clog2(NODES)
//  CELL_W      6   cell width: [5:4] bypass count, [3]=right, [2]=left, [1]=top, [0]=bot
//  MAX_HOPS    8   hop limit per path
//  MAX_BYPASS  2   largest legal bypass count on an intermediate node
// PORTS
//  clk          in   1       clock
//  reset        in   1       async, active-high
//  req_valid    in   1       edge request valid
//  req_ready    out  1       high only in IDLE
//  req_src      in   NODE_W  source PE
//  req_dst      in   NODE_W  destination PE
//  rd_en        out  1       table read strobe
//  rd_addr      out  NODE_W  table read address
//  rd_data      in   CELL_W  cell contents, valid the cycle after rd_en
//  hop_valid    out  1       hop output valid
//  hop_ready    in   1       hop output accept
//  hop_node     out  NODE_W  PE the hop leaves from
//  hop_dir      out  2       3=right, 2=left, 1=top, 0=bot
//  hop_last     out  1       hop arrives at dst
//  done_valid   out  1       one-cycle pulse: request finished
//  done_status  out  2       0 OK, 1 BROKEN, 2 TOO_LONG, 3 BYPASS
//  done_hops    out  4       hops emitted for this request
// BEHAVIOUR
//  Reset (async, active-high): state=IDLE. Every output is 0 except req_ready=1. Internal cur/dst/hops=0.
//  Reset mid-request: the request is abandoned, no done pulse, and any hop in flight is dropped.
//  FSM states: IDLE, FETCH, DECIDE, EMIT, DONE.
//  IDLE
//   - req_valid&&req_ready: latch cur=src and dst, set hops=0.
//   - If src==dst, go to DONE with OK and 0 hops; otherwise go to FETCH.
//  FETCH: rd_en=1, rd_addr=cur, go to DECIDE. No other state asserts rd_en.
//  DECIDE: rd_data is valid this cycle.
//   - Derive cc=cur%GRID, cr=cur/GRID, dc=dst%GRID, dr=dst/GRID.
//   - Direction choice, X before Y, first match wins:
//     dc>cc && bit3 -> right (next=cur+1);     dc<cc && bit2 -> left (next=cur-1);
//     dr>cr && bit0 -> bot (next=cur+GRID);    dr<cr && bit1 -> top (next=cur-GRID).
//   - No match -> DONE with BROKEN.
//   - If hops!=0 (intermediate node) and rd_data[5:4]>MAX_BYPASS -> DONE with BYPASS. This check beats the direction choice.
//   - Otherwise register hop_node=cur, hop_dir, next and hop_last=(next==dst), then go to EMIT.
//  EMIT
//   - hop_valid=1; hop_node/dir/last hold stable until hop_ready.
//   - On handshake: cur=next, hops=hops+1.
//   - Then: hop_last -> DONE OK; else hops+1==MAX_HOPS -> DONE TOO_LONG; else FETCH.
//  DONE: done_valid=1 for exactly one cycle with status and hops, then IDLE.
//   - done_status/done_hops hold their values until the next done pulse.
//  Timing: with hop_ready tied high, req accept at edge T gives rd_en in T+1, hop_valid in T+3, and 3 cycles per hop.
//  Arithmetic: next is computed at NODE_W+1 bits and never wraps. The direction rules stop it leaving the grid.
//  The block never writes the table and does not check bits beyond the chosen direction.
// TESTING
//  1. Table right bits set at 0,1 plus bot at 2; req 0->6 (hop_ready=1)
//     -> hops (0,3),(1,3),(2,0,last); OK, done_hops=3.
//  2. Req 5->5 -> no rd_en, no hop; done_valid one cycle after accept with OK, 0 hops.
//  3. Req 0->3 with cell1 right bit clear
//     -> hop (0,3) emitted, then BROKEN with done_hops=1.
//  4. Path 0->6 with cell1 bypass=3 -> hop (0,3), then BYPASS; cell0 bypass=3 alone does not fail.
//  5. Test 1 with hop_ready low 5 cycles on each hop
//     -> hop_valid/hop_node/hop_dir stable, no extra rd_en, same sequence.
//  6. Reset asserted during EMIT of test 1 -> outputs 0 at once, req_ready=1, no done pulse;
//     a new req 0->6 then completes OK.

Source files
------------

// File: rtl/cgra_route_reader.sv
//------------------------------------------------------------------------------
// cgra_route_reader : walks one routed edge through the CGRA routing table and
// streams each hop out over valid/ready, ending with a status pulse.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module cgra_route_reader #(
  parameter int GRID       = 4,
  parameter int NODES      = 16,
  parameter int NODE_W     = 4,
  parameter int CELL_W     = 6,
  parameter int MAX_HOPS   = 8,
  parameter int MAX_BYPASS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [NODE_W-1:0] i_req_src,
  input  logic [NODE_W-1:0] i_req_dst,
  output logic              o_rd_en,
  output logic [NODE_W-1:0] o_rd_addr,
  input  logic [CELL_W-1:0] i_rd_data,
  output logic              o_hop_valid,
  input  logic              i_hop_ready,
  output logic [NODE_W-1:0] o_hop_node,
  output logic [1:0]        o_hop_dir,
  output logic              o_hop_last,
  output logic              o_done_valid,
  output logic [1:0]        o_done_status,
  output logic [3:0]        o_done_hops
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECIDE = 3'd2,
    S_EMIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [1:0] c_st_ok       = 2'd0;
  localparam logic [1:0] c_st_broken   = 2'd1;
  localparam logic [1:0] c_st_too_long = 2'd2;
  localparam logic [1:0] c_st_bypass   = 2'd3;
  localparam logic [1:0] c_max_bypass  = 2'(MAX_BYPASS);
  localparam logic [3:0] c_max_hops    = 4'(MAX_HOPS);
  localparam logic [NODE_W:0] c_grid   = (NODE_W+1)'(GRID);
  localparam logic [NODE_W:0] c_nodes  = (NODE_W+1)'(NODES);

  state_t              r_state;
  state_t              w_state_nx;
  logic [NODE_W-1:0]   r_cur;
  logic [NODE_W-1:0]   r_dst;
  logic [3:0]          r_hops;
  logic [NODE_W:0]     r_next;
  logic [NODE_W-1:0]   r_hop_node;
  logic [1:0]          r_hop_dir;
  logic                r_hop_last;
  logic [1:0]          r_done_status;
  logic [3:0]          r_done_hops;

  logic [NODE_W-1:0]   w_cc, w_cr, w_dc, w_dr;
  logic [NODE_W:0]     w_cur_x;
  logic [NODE_W:0]     w_next;
  logic [1:0]          w_dir;
  logic                w_match;
  logic [3:0]          w_hops_inc;
  logic                w_load;
  logic                w_take;
  logic                w_hop_set;
  logic                w_done_set;
  logic [1:0]          w_done_st;
  logic [3:0]          w_done_hp;

  assign w_cc       = NODE_W'(r_cur % GRID);
  assign w_cr       = NODE_W'(r_cur / GRID);
  assign w_dc       = NODE_W'(r_dst % GRID);
  assign w_dr       = NODE_W'(r_dst / GRID);
  assign w_cur_x    = {1'b0, r_cur};
  assign w_hops_inc = r_hops + 4'd1;

  // X movement is preferred over Y; the first legal direction wins.
  always_comb begin
    w_match = 1'b0;
    w_dir   = 2'd0;
    w_next  = '0;
    if ((w_dc > w_cc) && i_rd_data[3]) begin
      w_match = 1'b1;
      w_dir   = 2'd3;
      w_next  = w_cur_x + (NODE_W+1)'(1);
    end else if ((w_dc < w_cc) && i_rd_data[2]) begin
      w_match = 1'b1;
      w_dir   = 2'd2;
      w_next  = w_cur_x - (NODE_W+1)'(1);
    end else if ((w_dr > w_cr) && i_rd_data[0]) begin
      w_match = 1'b1;
      w_dir   = 2'd0;
      w_next  = w_cur_x + c_grid;
    end else if ((w_dr < w_cr) && i_rd_data[1]) begin
      w_match = 1'b1;
      w_dir   = 2'd1;
      w_next  = w_cur_x - c_grid;
    end
    if (w_next >= c_nodes) begin
      w_match = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_load     = 1'b0;
    w_take     = 1'b0;
    w_hop_set  = 1'b0;
    w_done_set = 1'b0;
    w_done_st  = c_st_ok;
    w_done_hp  = r_hops;
    case (r_state)
      S_IDLE: begin
        if (i_req_valid) begin
          w_load = 1'b1;
          if (i_req_src == i_req_dst) begin
            w_state_nx = S_DONE;
            w_done_set = 1'b1;
            w_done_hp  = 4'd0;
          end else begin
            w_state_nx = S_FETCH;
          end
        end
      end
      S_FETCH: w_state_nx = S_DECIDE;
      S_DECIDE: begin
        // An over-long bypass chain on an intermediate PE overrides any direction.
        if ((r_hops != 4'd0) && (i_rd_data[5:4] > c_max_bypass)) begin
          w_state_nx = S_DONE;
          w_done_set = 1'b1;
          w_done_st  = c_st_bypass;
        end else if (!w_match) begin
          w_state_nx = S_DONE;
          w_done_set = 1'b1;
          w_done_st  = c_st_broken;
        end else begin
          w_state_nx = S_EMIT;
          w_hop_set  = 1'b1;
        end
      end
      S_EMIT: begin
        if (i_hop_ready) begin
          w_take    = 1'b1;
          w_done_hp = w_hops_inc;
          if (r_hop_last) begin
            w_state_nx = S_DONE;
            w_done_set = 1'b1;
          end else if (w_hops_inc == c_max_hops) begin
            w_state_nx = S_DONE;
            w_done_set = 1'b1;
            w_done_st  = c_st_too_long;
          end else begin
            w_state_nx = S_FETCH;
          end
        end
      end
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cur         <= '0;
      r_dst         <= '0;
      r_hops        <= '0;
      r_next        <= '0;
      r_hop_node    <= '0;
      r_hop_dir     <= '0;
      r_hop_last    <= 1'b0;
      r_done_status <= '0;
      r_done_hops   <= '0;
    end else begin
      if (w_load) begin
        r_cur  <= i_req_src;
        r_dst  <= i_req_dst;
        r_hops <= '0;
      end
      if (w_hop_set) begin
        r_hop_node <= r_cur;
        r_hop_dir  <= w_dir;
        r_next     <= w_next;
        r_hop_last <= (w_next == {1'b0, r_dst});
      end
      if (w_take) begin
        r_cur  <= r_next[NODE_W-1:0];
        r_hops <= w_hops_inc;
      end
      if (w_done_set) begin
        r_done_status <= w_done_st;
        r_done_hops   <= w_done_hp;
      end
    end
  end

  assign o_req_ready   = (r_state == S_IDLE);
  assign o_rd_en       = (r_state == S_FETCH);
  assign o_rd_addr     = o_rd_en ? r_cur : '0;
  assign o_hop_valid   = (r_state == S_EMIT);
  assign o_hop_node    = r_hop_node;
  assign o_hop_dir     = r_hop_dir;
  assign o_hop_last    = r_hop_last;
  assign o_done_valid  = (r_state == S_DONE);
  assign o_done_status = r_done_status;
  assign o_done_hops   = r_done_hops;

endmodule

`default_nettype wire
